// File: rtl/bp_fe_pc_seq_mw_if.sv
// Front-end PC sequencer bus: boot/stall controls, backend redirect,
// IF1 prediction and IF2 override inputs, plus the IF1/IF2 stage outputs.
interface bp_fe_pc_seq_mw_if #(
    parameter int vaddr_width_p = 39,
    parameter int fetch_bytes_p = 8,
    parameter int ghist_width_p = 8
);
    localparam int slots_lp  = fetch_bytes_p / 2;
    localparam int slot_w_lp = $clog2(slots_lp);

    logic                      init_done_i;
    logic [vaddr_width_p-1:0]  boot_pc_i;
    logic                      stall_i;
    logic                      redirect_v_i;
    logic [vaddr_width_p-1:0]  redirect_npc_i;
    logic                      redirect_resume_i;
    logic [ghist_width_p-1:0]  redirect_ghist_i;
    logic                      pred_v_i;
    logic                      pred_taken_i;
    logic                      pred_br_i;
    logic [slot_w_lp-1:0]      pred_slot_i;
    logic [vaddr_width_p-1:0]  pred_tgt_i;
    logic                      ovr_v_i;
    logic                      ovr_br_i;
    logic [vaddr_width_p-1:0]  ovr_tgt_i;
    logic [vaddr_width_p-1:0]  next_pc_o;
    logic                      if1_we_o;
    logic [vaddr_width_p-1:0]  if1_pc_o;
    logic                      if1_v_o;
    logic [vaddr_width_p-1:0]  if2_pc_o;
    logic                      if2_v_o;
    logic [slots_lp-1:0]       if2_mask_o;
    logic [ghist_width_p-1:0]  if2_ghist_o;
    logic                      halted_o;

    // Sequencer side
    modport slave (
        input  init_done_i, boot_pc_i, stall_i,
               redirect_v_i, redirect_npc_i, redirect_resume_i, redirect_ghist_i,
               pred_v_i, pred_taken_i, pred_br_i, pred_slot_i, pred_tgt_i,
               ovr_v_i, ovr_br_i, ovr_tgt_i,
        output next_pc_o, if1_we_o, if1_pc_o, if1_v_o,
               if2_pc_o, if2_v_o, if2_mask_o, if2_ghist_o, halted_o
    );

    // Driver side (backend / predictors)
    modport master (
        output init_done_i, boot_pc_i, stall_i,
               redirect_v_i, redirect_npc_i, redirect_resume_i, redirect_ghist_i,
               pred_v_i, pred_taken_i, pred_br_i, pred_slot_i, pred_tgt_i,
               ovr_v_i, ovr_br_i, ovr_tgt_i,
        input  next_pc_o, if1_we_o, if1_pc_o, if1_v_o,
               if2_pc_o, if2_v_o, if2_mask_o, if2_ghist_o, halted_o
    );
endinterface

// File: rtl/bp_fe_pc_seq_mw.sv
// Multi-wide next-PC sequencer: IF0 next-PC mux, IF1/IF2 PC pipeline,
// speculative global history and boot/halt control.
module bp_fe_pc_seq_mw #(
    parameter int vaddr_width_p = 39,
    parameter int fetch_bytes_p = 8,
    parameter int ghist_width_p = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bp_fe_pc_seq_mw_if.slave     io
);
    localparam int slots_lp  = fetch_bytes_p / 2;
    localparam int slot_w_lp = $clog2(slots_lp);
    localparam int offset_lp = $clog2(fetch_bytes_p);

    typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN, S_HALT} state_e;

    state_e                    state_q, state_d;
    logic [vaddr_width_p-1:0]  if1_pc_q, if2_pc_q;
    logic                      if1_v_q, if2_v_q;
    logic [slots_lp-1:0]       if2_mask_q;
    logic [ghist_width_p-1:0]  if2_ghist_q, ghist_q;

    logic [vaddr_width_p-1:0]  next_pc_d, seq_pc;
    logic                      if1_we_d;
    logic [slot_w_lp-1:0]      start_slot, end_slot, idx;
    logic [slots_lp-1:0]       mask_d;
    logic                      pred_hit, ovr_fire, redir_fire, advance;

    assign start_slot = if1_pc_q[offset_lp-1:1];
    assign seq_pc     = (if1_pc_q & ~vaddr_width_p'(fetch_bytes_p - 1))
                        + vaddr_width_p'(fetch_bytes_p);
    // A predicted CTI before the start slot cannot be in this block: ignore it
    assign pred_hit   = if1_v_q & io.pred_v_i & io.pred_taken_i
                        & (io.pred_slot_i >= start_slot);
    assign end_slot   = pred_hit ? io.pred_slot_i : '1;
    assign redir_fire = io.redirect_v_i & ((state_q == S_RUN) | (state_q == S_HALT));
    assign advance    = (state_q == S_RUN) & ~io.stall_i;
    assign ovr_fire   = advance & io.ovr_v_i & if2_v_q & ~io.redirect_v_i;

    // Slot mask for the block moving from IF1 to IF2
    always_comb begin
        mask_d = '0;
        idx    = '0;
        for (int unsigned i = 0; i < slots_lp; i++) begin
            idx       = slot_w_lp'(i);
            mask_d[i] = (idx >= start_slot) && (idx <= end_slot);
        end
    end

    // Next-state logic, next-PC priority mux and IF1 write enable
    always_comb begin
        state_d   = state_q;
        if1_we_d  = 1'b0;
        if (io.redirect_v_i)  next_pc_d = io.redirect_npc_i;
        else if (ovr_fire)    next_pc_d = io.ovr_tgt_i;
        else if (pred_hit)    next_pc_d = io.pred_tgt_i;
        else                  next_pc_d = seq_pc;
        unique case (state_q)
            S_RESET: begin
                next_pc_d = '0;
                state_d   = S_INIT;
            end
            S_INIT: begin
                next_pc_d = io.boot_pc_i;
                if (io.init_done_i) begin
                    if1_we_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (io.redirect_v_i) begin
                    if1_we_d = io.redirect_resume_i;
                    if (!io.redirect_resume_i) state_d = S_HALT;
                end else begin
                    if1_we_d = ~io.stall_i;
                end
            end
            S_HALT: begin
                if (io.redirect_v_i && io.redirect_resume_i) begin
                    if1_we_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            default: state_d = S_RESET;
        endcase
        if (!reset_n_i) if1_we_d = 1'b0;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_q <= S_RESET;
        else            state_q <= state_d;
    end

    // IF1/IF2 pipeline and speculative history
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            if1_pc_q    <= '0;
            if1_v_q     <= 1'b0;
            if2_pc_q    <= '0;
            if2_v_q     <= 1'b0;
            if2_mask_q  <= '0;
            if2_ghist_q <= '0;
            ghist_q     <= '0;
        end else if ((state_q == S_INIT) && io.init_done_i) begin
            if1_pc_q <= io.boot_pc_i;
            if1_v_q  <= 1'b1;
        end else if (redir_fire) begin
            if1_pc_q <= io.redirect_npc_i;
            if1_v_q  <= io.redirect_resume_i;
            if2_v_q  <= 1'b0;
            ghist_q  <= io.redirect_ghist_i;
        end else if (advance) begin
            if2_pc_q    <= if1_pc_q;
            // The squashed IF1 block becomes an invalid IF2 bubble on override
            if2_v_q     <= if1_v_q & ~ovr_fire;
            if2_mask_q  <= mask_d;
            if2_ghist_q <= ghist_q;
            if1_pc_q    <= next_pc_d;
            if1_v_q     <= 1'b1;
            if (ovr_fire)
                ghist_q <= io.ovr_br_i ? {if2_ghist_q[ghist_width_p-2:0], 1'b1} : if2_ghist_q;
            else if (if1_v_q && io.pred_v_i && io.pred_br_i)
                ghist_q <= {ghist_q[ghist_width_p-2:0], io.pred_taken_i};
        end
    end

    assign io.next_pc_o   = next_pc_d;
    assign io.if1_we_o    = if1_we_d;
    assign io.if1_pc_o    = if1_pc_q;
    assign io.if1_v_o     = if1_v_q;
    assign io.if2_pc_o    = if2_pc_q;
    assign io.if2_v_o     = if2_v_q;
    assign io.if2_mask_o  = if2_mask_q;
    assign io.if2_ghist_o = if2_ghist_q;
    assign io.halted_o    = (state_q == S_HALT);
endmodule
